// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the retirement stage.
// ROB entry state constants also used by the ROB and decode.
package rob_commit_unit_pkg;

    typedef enum logic {
        CU_IDLE = 1'b0,
        CU_REQ  = 1'b1
    } cu_state_e;

    localparam logic [1:0] ROB_FREE = 2'b00;
    localparam logic [1:0] ROB_PEND = 2'b01;
    localparam logic [1:0] ROB_FIN  = 2'b10;

endpackage

// File: rtl/rob_commit_unit_store_buffer_fifo.sv
// In-order circular store buffer holding {addr, data} pairs.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module store_buffer_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Retirement stage: register-file writeback, commit back-pressure and
// in-order store drain to data memory over a req/ack handshake.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      head_finished,
    input  logic                      head_is_store,
    input  logic                      head_wr_rf,
    input  logic [4:0]                head_rd,
    input  logic [DATA_W-1:0]         head_value,
    input  logic [ADDR_W-1:0]         head_addr,
    input  logic                      commit_fire,
    output logic                      commit_allow,
    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty,
    output logic [CNT_W-1:0]          retired_cnt,
    output logic [CNT_W-1:0]          stores_done_cnt
);

    localparam int SB_CNT_W = $clog2(SB_DEPTH) + 1;

    cu_state_e         state_q;
    cu_state_e         state_d;
    logic              load_req;
    logic              pop_this_cycle;
    logic              sb_push;
    logic              sb_full;
    logic              sb_fifo_empty;
    logic [ADDR_W-1:0] sb_head_addr;
    logic [DATA_W-1:0] sb_head_data;

    // A full buffer still admits a store in the cycle its head is acknowledged.
    assign commit_allow = ~head_is_store | (sb_count < SB_CNT_W'(SB_DEPTH)) | pop_this_cycle;
    assign sb_push      = commit_fire & head_is_store & commit_allow;

    assign rf_we    = commit_fire & head_wr_rf & ~head_is_store & (head_rd != 5'd0);
    assign rf_waddr = head_rd;
    assign rf_wdata = head_value;

    assign sb_empty = (sb_count == '0) & (state_q == CU_IDLE);

    store_buffer_fifo #(
        .DEPTH  (SB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .push      (sb_push),
        .push_addr (head_addr),
        .push_data (head_value),
        .pop       (pop_this_cycle),
        .full      (sb_full),
        .empty     (sb_fifo_empty),
        .count     (sb_count),
        .head_addr (sb_head_addr),
        .head_data (sb_head_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= CU_IDLE;
        else     state_q <= state_d;
    end

    // The pass through IDLE after every ack limits drain to one store per two cycles.
    always_comb begin
        state_d        = state_q;
        load_req       = 1'b0;
        pop_this_cycle = 1'b0;
        case (state_q)
            CU_IDLE: begin
                if (sb_count != '0) begin
                    load_req = 1'b1;
                    state_d  = CU_REQ;
                end
            end
            CU_REQ: begin
                if (mem_ack) begin
                    pop_this_cycle = 1'b1;
                    state_d        = CU_IDLE;
                end
            end
            default: state_d = CU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load_req) begin
            mem_req   <= 1'b1;
            mem_addr  <= sb_head_addr;
            mem_wdata <= sb_head_data;
        end else if (pop_this_cycle) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt     <= '0;
            stores_done_cnt <= '0;
        end else begin
            if (commit_fire)    retired_cnt     <= retired_cnt + 1'b1;
            if (pop_this_cycle) stores_done_cnt <= stores_done_cnt + 1'b1;
        end
    end

    a_no_fire_without_allow: assert property (@(posedge clk) disable iff (rst)
        !(commit_fire && !commit_allow));

endmodule

// File: tb/tb_rob_commit_unit.sv
// Randomized self-checking bench for rob_commit_unit against a queue-based
// model of the store buffer, drain handshake and retirement counters.
module tb_rob_commit_unit;

    localparam int SB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        head_finished;
    logic        head_is_store;
    logic        head_wr_rf;
    logic [4:0]  head_rd;
    logic [31:0] head_value;
    logic [31:0] head_addr;
    logic        commit_fire;
    logic        commit_allow;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [2:0]  sb_count;
    logic        sb_empty;
    logic [15:0] retired_cnt;
    logic [15:0] stores_done_cnt;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] qAddr[$];
    logic [31:0] qData[$];
    bit          mReq;
    logic [31:0] mAddr;
    logic [31:0] mData;
    logic [15:0] mRetired;
    logic [15:0] mDone;

    rob_commit_unit #(
        .SB_DEPTH (SB_DEPTH),
        .ADDR_W   (32),
        .DATA_W   (32),
        .CNT_W    (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .head_finished   (head_finished),
        .head_is_store   (head_is_store),
        .head_wr_rf      (head_wr_rf),
        .head_rd         (head_rd),
        .head_value      (head_value),
        .head_addr       (head_addr),
        .commit_fire     (commit_fire),
        .commit_allow    (commit_allow),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .sb_count        (sb_count),
        .sb_empty        (sb_empty),
        .retired_cnt     (retired_cnt),
        .stores_done_cnt (stores_done_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic checkRegistered();
        checkOutput("mem_req", 32'(mem_req), 32'(mReq));
        if (mReq) begin
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("mem_wdata", mem_wdata, mData);
        end
        checkOutput("sb_count", 32'(sb_count), 32'(qAddr.size()));
        checkOutput("sb_empty", 32'(sb_empty), 32'(qAddr.size() == 0 && !mReq));
        checkOutput("retired_cnt", 32'(retired_cnt), 32'(mRetired));
        checkOutput("stores_done_cnt", 32'(stores_done_cnt), 32'(mDone));
    endtask

    // One clock cycle: check state, drive a head bundle, check same-cycle outputs, advance the model.
    task automatic applyStimulus(input bit rstIn, input bit fin, input bit store, input bit wrRf,
                                 input logic [4:0] rd, input logic [31:0] value, input logic [31:0] addr,
                                 input bit robReady, input bit ack);
        bit expAllow, fire, expWe;
        @(negedge clk);
        checkRegistered();
        expAllow = !store || (qAddr.size() < SB_DEPTH) || (mReq && ack);
        fire     = !rstIn && fin && robReady && expAllow;
        rst           = rstIn;
        head_finished = fin;
        head_is_store = store;
        head_wr_rf    = wrRf;
        head_rd       = rd;
        head_value    = value;
        head_addr     = addr;
        mem_ack       = ack;
        commit_fire   = fire;
        #1;
        checkOutput("commit_allow", 32'(commit_allow), 32'(expAllow));
        expWe = fire && wrRf && !store && (rd != 5'd0);
        checkOutput("rf_we", 32'(rf_we), 32'(expWe));
        if (expWe) begin
            checkOutput("rf_waddr", 32'(rf_waddr), 32'(rd));
            checkOutput("rf_wdata", rf_wdata, value);
        end
        @(posedge clk);
        if (rstIn) begin
            qAddr.delete();
            qData.delete();
            mReq = 0;
            mRetired = '0;
            mDone = '0;
        end else begin
            if (mReq && ack) begin
                void'(qAddr.pop_front());
                void'(qData.pop_front());
                mReq = 0;
                mDone = mDone + 16'd1;
            end else if (!mReq && qAddr.size() != 0) begin
                mReq  = 1;
                mAddr = qAddr[0];
                mData = qData[0];
            end
            if (fire && store) begin
                qAddr.push_back(addr);
                qData.push_back(value);
            end
            if (fire) mRetired = mRetired + 16'd1;
        end
    endtask

    task automatic idleCycle(input bit ack);
        applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, ack);
    endtask

    task automatic commitStore(input logic [31:0] addr, input logic [31:0] data, input bit ack);
        applyStimulus(0, 1, 1, 0, 5'd0, data, addr, 1, ack);
    endtask

    initial begin
        rst = 1'b1; head_finished = 0; head_is_store = 0; head_wr_rf = 0;
        head_rd = '0; head_value = '0; head_addr = '0; commit_fire = 0; mem_ack = 0;
        mReq = 0; mAddr = '0; mData = '0; mRetired = '0; mDone = '0;

        applyStimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'h0);

        // ALU retire and r0 suppression
        applyStimulus(0, 1, 0, 1, 5'd5, 32'h0000_00AA, 32'h0, 1, 0);
        applyStimulus(0, 1, 0, 1, 5'd0, 32'h0000_0055, 32'h0, 1, 0);

        // Single store with delayed ack
        commitStore(32'h100, 32'hDEAD_BEEF, 0);
        repeat (4) idleCycle(0);
        idleCycle(1);
        repeat (2) idleCycle(0);

        // Fill the buffer, probe back-pressure, then push in the pop cycle
        for (int i = 0; i < 4; i++) commitStore(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
        idleCycle(0);
        commitStore(32'h2F0, 32'hBAD0_0000, 0);
        applyStimulus(0, 1, 0, 1, 5'd7, 32'h1234_5678, 32'h0, 1, 0);
        commitStore(32'h210, 32'hA000_0004, 1);
        repeat (12) idleCycle(1);

        // Ordering with immediate acks
        commitStore(32'h10, 32'h1, 1);
        commitStore(32'h20, 32'h2, 1);
        commitStore(32'h30, 32'h3, 1);
        repeat (7) idleCycle(1);

        // Reset while a request is outstanding
        commitStore(32'h400, 32'h4, 0);
        commitStore(32'h404, 32'h5, 0);
        commitStore(32'h408, 32'h6, 0);
        applyStimulus(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 0);
        idleCycle(1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 31)),
                          $urandom(),
                          $urandom(),
                          ($urandom_range(0, 4) != 0),
                          ($urandom_range(0, 9) < 4));
        end
        idleCycle(0);
        @(negedge clk);
        checkRegistered();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
